// File: rtl/cont_sequencer.sv
// Run controller for a 4-digit BCD counter: prescaled count-enable tick, start/stop/clear FSM, target match.
// Latency: commands and match take effect one edge after sampling; all outputs are registered.
// Backpressure: none; commands are single-cycle pulses (clear > stop > start); build option CONT_AUTORELOAD_EN.
module cont_sequencer #(
    parameter int PRESCALE = 50_000_000,
    parameter int PS_W     = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [15:0] target,
    input  logic [15:0] count,
    output logic        tick,
    output logic        cnt_clr,
    output logic        running,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    state_t          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_d, clr_d, done_d, running_d;
    logic            match, ps_wrap;

    // The counter still shows the old value during the cnt_clr cycle, so
    // a match seen then is stale and must be ignored.
`ifdef CONT_AUTORELOAD_EN
    assign match = (count == target) && (target != 16'h0000) && !cnt_clr;
`else
    assign match = (count == target) && !cnt_clr;
`endif

    assign ps_wrap = (ps_q == PS_LAST);

    // Next-state, prescaler and registered-output decode.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    clr_d = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    ps_d    = '0;
                end
            end
            RUN: begin
                if (clear) begin
                    clr_d   = 1'b1;
                    ps_d    = '0;
                    state_d = IDLE;
                end else if (stop) begin
                    // Prescaler holds, so a partial period resumes intact.
                    state_d = PAUSE;
                end else if (match) begin
`ifdef CONT_AUTORELOAD_EN
                    // Reload: clear the counter, keep the prescaler phase,
                    // drop any tick that would collide with the clear.
                    clr_d  = 1'b1;
                    done_d = 1'b1;
                    ps_d   = ps_wrap ? '0 : ps_q + PS_ONE;
`else
                    state_d = DONE;
`endif
                end else if (ps_wrap) begin
                    ps_d   = '0;
                    tick_d = 1'b1;
                end else begin
                    ps_d = ps_q + PS_ONE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    clr_d   = 1'b1;
                    ps_d    = '0;
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    clr_d   = 1'b1;
                    ps_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifndef CONT_AUTORELOAD_EN
        done_d = (state_d == DONE);
`endif
        running_d = (state_d == RUN);
    end

    // State, prescaler and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ps_q    <= '0;
            tick    <= 1'b0;
            cnt_clr <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            tick    <= tick_d;
            cnt_clr <= clr_d;
            running <= running_d;
            done    <= done_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cont_sequencer.sv
// Directed bench for cont_sequencer with an attached BCD counter model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; all waits are fixed cycle counts.
module tb_cont_sequencer;

`ifdef CONT_AUTORELOAD_EN
    localparam int P = 2;
`else
    localparam int P = 4;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] target;
    logic [15:0] model_cnt;
    logic        tick;
    logic        cnt_clr;
    logic        running;
    logic        done;
    logic [1:0]  state;

    logic        load;
    logic [15:0] load_val;

    int checks = 0;
    int errors = 0;

    cont_sequencer #(.PRESCALE(P), .PS_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .target  (target),
        .count   (model_cnt),
        .tick    (tick),
        .cnt_clr (cnt_clr),
        .running (running),
        .done    (done),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Counter datapath model: clear wins over enable.
    always @(posedge clk) begin
        if (reset || cnt_clr)
            model_cnt <= 16'h0000;
        else if (load)
            model_cnt <= load_val;
        else if (tick)
            model_cnt <= bcd_inc(model_cnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic t, input logic c);
        start = s;
        stop  = t;
        clear = c;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        target   = 16'h0000;
        load     = 1'b0;
        load_val = 16'h0000;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_state",   state,   0);
        check("rst_tick",    tick,    0);
        check("rst_cnt_clr", cnt_clr, 0);
        check("rst_running", running, 0);
        check("rst_done",    done,    0);

`ifdef CONT_AUTORELOAD_EN
        target = 16'h0002;
        pulse(1'b1, 1'b0, 1'b0);
        check("ar_state0", state, 1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("ar_state",   state,   1);
            check("ar_cnt_clr", cnt_clr, (i % 6 == 0));
            check("ar_done",    done,    (i % 6 == 0));
            check("ar_tick",    tick,    (i % 6 == 2) || (i % 6 == 4));
            check("ar_count",   model_cnt, (i % 6 == 0 || i % 6 == 5) ? 2 :
                                           (i % 6 == 3 || i % 6 == 4) ? 1 : 0);
        end
`else
        // Run to target 0003: ticks after edges +4, +8, +12; DONE after +14.
        target = 16'h0003;
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_state0",   state,   1);
        check("t1_running0", running, 1);
        for (int i = 1; i <= 18; i++) begin
            cyc();
            check("t1_tick",  tick,  (i == 4) || (i == 8) || (i == 12));
            check("t1_state", state, (i >= 14) ? 3 : 1);
            check("t1_done",  done,  (i >= 14));
            if (i == 13)
                check("t1_count3", model_cnt, 16'h0003);
        end
        pulse(1'b0, 1'b0, 1'b1);
        check("t1_clr_state", state,   0);
        check("t1_clr_pulse", cnt_clr, 1);
        check("t1_clr_done",  done,    0);
        cyc();
        check("t1_clr_end",   cnt_clr, 0);
        check("t1_clr_count", model_cnt, 16'h0000);

        // Target 0000 with count 0000: DONE after the first RUN cycle, no tick.
        target = 16'h0000;
        pulse(1'b1, 1'b0, 1'b0);
        check("z_state_run", state, 1);
        cyc();
        check("z_state_done", state, 3);
        check("z_done",       done,  1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("z_tick", tick, 0);
        end
        pulse(1'b0, 1'b0, 1'b1);
        cyc();

        // Pause two cycles after a tick; resume gives the remaining 2 RUN cycles.
        target = 16'h0050;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("p_tick_pre", tick, (i == 4));
        end
        pulse(1'b0, 1'b1, 1'b0);
        check("p_state",   state,   2);
        check("p_running", running, 0);
        check("p_tick",    tick,    0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("p_hold_tick",  tick,      0);
            check("p_hold_count", model_cnt, 16'h0001);
            check("p_hold_state", state,     2);
        end
        pulse(1'b1, 1'b0, 1'b0);
        check("p_resume_state", state, 1);
        check("p_resume_tick",  tick,  0);
        cyc();
        check("p_r1_tick", tick, 0);
        cyc();
        check("p_r2_tick", tick, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("p_after_tick", tick, 0);
        end

        // All three commands together with a tick due: clear wins.
        pulse(1'b1, 1'b1, 1'b1);
        check("all_cnt_clr", cnt_clr, 1);
        check("all_state",   state,   0);
        check("all_running", running, 0);
        check("all_tick",    tick,    0);
        cyc();
        check("all_clr_end", cnt_clr,   0);
        check("all_tick2",   tick,      0);
        check("all_count",   model_cnt, 16'h0000);

        // Reset with a tick due next cycle.
        pulse(1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("r_tick",    tick,    0);
        check("r_cnt_clr", cnt_clr, 0);
        check("r_running", running, 0);
        check("r_done",    done,    0);
        check("r_state",   state,   0);
        cyc();

        // Invalid BCD target: never DONE, count wraps 9999 -> 0000.
        load_val = 16'h9998;
        load     = 1'b1;
        cyc();
        load   = 1'b0;
        target = 16'h00A0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            cyc();
            check("w_state", state, 1);
            if (i == 5)  check("w_9999", model_cnt, 16'h9999);
            if (i == 9)  check("w_0000", model_cnt, 16'h0000);
            if (i == 13) check("w_0001", model_cnt, 16'h0001);
        end
        check("w_done", done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
